// File: rtl/serial_pkg.sv
// Shared constants for the bit-serial subtractor: FSM encoding, default width, counter sizing.
package serial_pkg;

  localparam int DEF_WIDTH = 8;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // Bit counter width; never narrower than one bit so the counter stays declarable.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/serial_full_subtractor.sv
// One-bit full subtractor cell with its borrow flip-flop; borrow clears on clr, advances on en.
module serial_full_subtractor (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  input  logic min_bit,
  input  logic sub_bit,
  output logic diff_bit,
  output logic borrow_next,
  output logic borrow
);

  assign diff_bit    = min_bit ^ sub_bit ^ borrow;
  assign borrow_next = (~min_bit & sub_bit) | (~(min_bit ^ sub_bit) & borrow);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      borrow <= 1'b0;
    end else if (clr) begin
      borrow <= 1'b0;
    end else if (en) begin
      borrow <= borrow_next;
    end
  end

endmodule

// File: rtl/serial_subtractor_unit.sv
// Sequencer and datapath for LSB-first serial subtraction; Start-to-Done latency is WIDTH+2 cycles.
// Start is only accepted in IDLE; result registers update solely on entry to DONE.
module serial_subtractor_unit
  import serial_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             Start,
  input  logic             Min,
  input  logic             Sub,
  output logic             L,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Diff,
  output logic             Borrow,
  output logic             Ovf
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] res;
  logic             in_load;
  logic             in_shift;
  logic             last_bit;
  logic             d;
  logic             b_nxt;
  logic             b;

  assign in_load  = (state == S_LOAD);
  assign in_shift = (state == S_SHIFT);
  assign last_bit = in_shift && (cnt == LAST);

  assign L    = in_load;
  assign Busy = (state != S_IDLE);
  assign Done = (state == S_DONE);

  serial_full_subtractor u_cell (
    .clk         (CLK),
    .rst_n       (RSTn),
    .clr         (in_load),
    .en          (in_shift),
    .min_bit     (Min),
    .sub_bit     (Sub),
    .diff_bit    (d),
    .borrow_next (b_nxt),
    .borrow      (b)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  state_nxt = Start ? S_LOAD : S_IDLE;
      S_LOAD:  state_nxt = S_SHIFT;
      S_SHIFT: state_nxt = last_bit ? S_DONE : S_SHIFT;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state <= S_IDLE;
      cnt   <= '0;
      res   <= '0;
    end else begin
      state <= state_nxt;
      if (in_load) begin
        cnt <= '0;
        res <= '0;
      end else if (in_shift) begin
        cnt <= cnt + CW'(1);
        res <= {d, res[WIDTH-1:1]};
      end
    end
  end

  // The last SHIFT edge carries the MSBs, so the flags are formed from the live cell values here.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      Diff   <= '0;
      Borrow <= 1'b0;
      Ovf    <= 1'b0;
    end else if (last_bit) begin
      Diff   <= {d, res[WIDTH-1:1]};
      Borrow <= b_nxt;
      Ovf    <= (Min != Sub) && (d != Min);
    end
  end

endmodule

// File: tb/tb_serial_subtractor_unit.sv
// Bench for serial_subtractor_unit: behavioural operand shift registers plus a result scoreboard.
module tb_serial_subtractor_unit;
  localparam int W = 8;

  typedef struct packed {
    logic [7:0] d;
    logic       b;
    logic       o;
  } exp_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] s;
    logic [7:0] d;
    logic       b;
    logic       o;
  } vec_t;

  logic         CLK;
  logic         RSTn;
  logic         Start;
  logic         Min;
  logic         Sub;
  logic         L;
  logic         Busy;
  logic         Done;
  logic [W-1:0] Diff;
  logic         Borrow;
  logic         Ovf;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int l_cnt = 0;
  int done_cnt = 0;

  logic [7:0]  min_sr = '0;
  logic [7:0]  sub_sr = '0;
  logic [15:0] opq[$];
  exp_t        expq[$];
  int          startq[$];

  serial_subtractor_unit #(.WIDTH(W)) dut (
    .CLK    (CLK),
    .RSTn   (RSTn),
    .Start  (Start),
    .Min    (Min),
    .Sub    (Sub),
    .L      (L),
    .Busy   (Busy),
    .Done   (Done),
    .Diff   (Diff),
    .Borrow (Borrow),
    .Ovf    (Ovf)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Neighbouring operand registers: load on L, otherwise shift one bit toward Sout.
  assign Min = min_sr[0];
  assign Sub = sub_sr[0];
  always @(posedge CLK) begin
    if (L) begin
      if (opq.size() > 0) begin
        {min_sr, sub_sr} <= opq.pop_front();
      end
    end else begin
      min_sr <= min_sr >> 1;
      sub_sr <= sub_sr >> 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: timeout (t=%0t)", name, $time);
  endtask

  // Scoreboard side: every Done pops one expected result.
  always @(negedge CLK) begin
    exp_t e;
    int   s;
    if (L) l_cnt++;
    if (Done) begin
      done_cnt++;
      if (expq.size() == 0) begin
        fail_now("unexpected_done");
      end else begin
        e = expq.pop_front();
        s = startq.pop_front();
        check("diff", 32'(Diff), 32'(e.d));
        check("borrow", 32'(Borrow), 32'(e.b));
        check("ovf", 32'(Ovf), 32'(e.o));
        if (s >= 0) check("latency", 32'(cyc - s), 32'(W + 2));
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge CLK);
    while (Busy && n < 40) begin
      @(negedge CLK);
      n++;
    end
    if (Busy) fail_now("wait_idle");
  endtask

  task automatic wait_done();
    int n = 0;
    while (!Done && n < 40) begin
      @(negedge CLK);
      n++;
    end
    if (!Done) fail_now("wait_done");
    @(negedge CLK);
  endtask

  task automatic kick(input logic [7:0] a, input logic [7:0] s, input logic [7:0] d,
                      input logic b, input logic o);
    opq.push_back({a, s});
    expq.push_back('{d: d, b: b, o: o});
    startq.push_back(cyc);
    Start = 1'b1;
    @(negedge CLK);
    Start = 1'b0;
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] s, input logic [7:0] d,
                        input logic b, input logic o);
    wait_idle();
    kick(a, s, d, b, o);
    wait_done();
  endtask

  vec_t vecs[7];

  initial begin
    int   l0;
    int   d0;
    int   n;
    int   last_done;
    logic [7:0] held;

    vecs[0] = '{a: 8'hA4, s: 8'h6D, d: 8'h37, b: 1'b0, o: 1'b1};
    vecs[1] = '{a: 8'h05, s: 8'h07, d: 8'hFE, b: 1'b1, o: 1'b0};
    vecs[2] = '{a: 8'h80, s: 8'h01, d: 8'h7F, b: 1'b0, o: 1'b1};
    vecs[3] = '{a: 8'h3C, s: 8'h3C, d: 8'h00, b: 1'b0, o: 1'b0};
    vecs[4] = '{a: 8'h00, s: 8'hFF, d: 8'h01, b: 1'b1, o: 1'b0};
    vecs[5] = '{a: 8'h7F, s: 8'hFF, d: 8'h80, b: 1'b1, o: 1'b1};
    vecs[6] = '{a: 8'hFF, s: 8'hFF, d: 8'h00, b: 1'b0, o: 1'b0};

    RSTn  = 1'b0;
    Start = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_l", 32'(L), 0);
    check("rst_busy", 32'(Busy), 0);
    check("rst_done", 32'(Done), 0);
    check("rst_diff", 32'(Diff), 0);
    check("rst_borrow", 32'(Borrow), 0);
    check("rst_ovf", 32'(Ovf), 0);
    RSTn = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].a, vecs[i].s, vecs[i].d, vecs[i].b, vecs[i].o);
    end

    // A second Start pulse mid-SHIFT must not queue another operation.
    wait_idle();
    l0 = l_cnt;
    d0 = done_cnt;
    kick(8'hA4, 8'h6D, 8'h37, 1'b0, 1'b1);
    repeat (4) @(negedge CLK);
    Start = 1'b1;
    @(negedge CLK);
    Start = 1'b0;
    wait_done();
    repeat (15) @(negedge CLK);
    check("ignored_start_l", 32'(l_cnt - l0), 1);
    check("ignored_start_done", 32'(done_cnt - d0), 1);

    // Reset in the middle of SHIFT: no result must survive.
    wait_idle();
    opq.push_back({8'h12, 8'h34});
    Start = 1'b1;
    @(negedge CLK);
    Start = 1'b0;
    repeat (5) @(negedge CLK);
    check("mid_busy", 32'(Busy), 1);
    RSTn = 1'b0;
    #1;
    check("abort_l", 32'(L), 0);
    check("abort_busy", 32'(Busy), 0);
    check("abort_done", 32'(Done), 0);
    check("abort_diff", 32'(Diff), 0);
    check("abort_borrow", 32'(Borrow), 0);
    check("abort_ovf", 32'(Ovf), 0);
    repeat (2) @(negedge CLK);
    opq.delete();
    RSTn = 1'b1;
    run_op(8'h10, 8'h01, 8'h0F, 1'b0, 1'b0);

    // Start held high: three operations back to back.
    wait_idle();
    opq.push_back({8'hC8, 8'h32});
    opq.push_back({8'h01, 8'h02});
    opq.push_back({8'h7F, 8'h80});
    expq.push_back('{d: 8'h96, b: 1'b0, o: 1'b0});
    expq.push_back('{d: 8'hFF, b: 1'b1, o: 1'b0});
    expq.push_back('{d: 8'hFF, b: 1'b1, o: 1'b1});
    startq.push_back(cyc);
    startq.push_back(-1);
    startq.push_back(-1);
    Start = 1'b1;
    n = 0;
    last_done = 0;
    held = '0;
    for (int k = 0; k < 200 && n < 3; k++) begin
      @(negedge CLK);
      if (Done) begin
        if (n > 0) check("b2b_spacing", 32'(cyc - last_done), 32'(W + 3));
        n++;
        last_done = cyc;
        held = Diff;
        if (n == 3) Start = 1'b0;
      end else if (n > 0) begin
        check("b2b_diff_hold", 32'(Diff), 32'(held));
      end
    end
    Start = 1'b0;
    if (n < 3) fail_now("b2b_done");
    repeat (15) @(negedge CLK);
    check("b2b_idle", 32'(Busy), 0);
    check("scoreboard_empty", 32'(expq.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_subtractor_unit.md
# serial_subtractor_unit

Bit-serial subtraction stage that sits directly downstream of the minuend and subtrahend operand shift registers. It sequences those registers by issuing their load strobe, consumes one bit from each per clock (LSB first), and forms the difference with a single borrow flip-flop. It then presents the parallel result with its borrow and signed-overflow flags. This block is the arithmetic core and sequencer of the serial subtractor datapath.

## Interface
- WIDTH, 8, operand/result width in bits; also the number of SHIFT cycles
- CLK  in  1  system clock; all state updates on rising edge
- RSTn  in  1  reset, asynchronous, active-low
- Start  in  1  request a subtraction; sampled only in IDLE
- Min  in  1  serial minuend bit from the minuend shift register's Sout
- Sub  in  1  serial subtrahend bit from the subtrahend shift register's Sout
- L  out  1  load strobe driven to both operand shift registers
- Busy  out  1  high in every state except IDLE
- Done  out  1  one-cycle completion pulse
- Diff  out  WIDTH  parallel result Min−Sub mod 2^WIDTH, held between completions
- Borrow  out  1  final borrow; 1 iff unsigned minuend < subtrahend
- Ovf  out  1  two's-complement overflow of the subtraction

## Operation
- FSM states: IDLE, LOAD, SHIFT, DONE.
- IDLE → LOAD when Start=1; otherwise stay in IDLE.
- LOAD: lasts 1 cycle. L=1. Clear the borrow FF, bit counter and internal result shift register. Next state is SHIFT.
- SHIFT: lasts exactly WIDTH cycles; the counter runs 0..WIDTH−1.
  - Difference bit: d = Min ^ Sub ^ b.
  - Next borrow: b' = (~Min & Sub) | (~(Min ^ Sub) & b).
  - d shifts into the MSB of the internal result register, which shifts right.
  - On counter = WIDTH−1, latch the MSBs of Min, Sub and d for overflow.
- DONE: lasts 1 cycle. Done=1.
  - Diff ← internal result.
  - Borrow ← b.
  - Ovf ← (Min_msb ≠ Sub_msb) & (d_msb ≠ Min_msb).
  - Next state is IDLE.
- Start is ignored in LOAD, SHIFT and DONE. It is not queued.
- Start held high through DONE begins a new operation on the first IDLE cycle, giving back-to-back operations.
- Diff, Borrow and Ovf change only on entry to DONE. They keep their previous values during a new operation.
- Neighbour contract: after an edge where L=1, the operand registers present bit 0 on Sout in the first SHIFT cycle. They advance one bit on each edge where L=0.

## Timing
- Reset values while RSTn=0: state=IDLE; L=0, Busy=0, Done=0, Diff=0, Borrow=0, Ovf=0; counter=0, borrow FF=0, internal result=0.
- Reset asserted mid-operation aborts immediately. Partial results are discarded, and the previous Diff is not retained.
- Timeline for Start sampled high at edge t:
  - L=1 during cycle t+1.
  - SHIFT occupies cycles t+2 … t+WIDTH+1.
  - Done=1 and the new Diff/Borrow/Ovf appear in cycle t+WIDTH+2.
- Latency from Start to Done is WIDTH+2 cycles. The minimum Start-to-Start spacing is WIDTH+3 cycles.
- Busy=1 from cycle t+1 through cycle t+WIDTH+2 inclusive.
- Min and Sub are sampled only in SHIFT; they are don't-care elsewhere.

## Structure
- Shared package `serial_pkg`:
  - state encoding localparams S_IDLE=2'd0, S_LOAD=2'd1, S_SHIFT=2'd2, S_DONE=2'd3
  - default WIDTH=8
  - counter width $clog2(WIDTH)
- Sub-module `serial_full_subtractor`: combinational d/b' bit cell plus the borrow FF, with a synchronous clear from LOAD and asynchronous reset from RSTn.
- The top level holds the FSM, counter, result shift register and output registers.

## Test plan
- Minuend 0xA4, subtrahend 0x6D (operand registers loaded by L) → Diff=0x37, Borrow=0, Ovf=1; Done exactly WIDTH+2 cycles after Start.
- 0x05 − 0x07 → Diff=0xFE, Borrow=1, Ovf=0.
- 0x80 − 0x01 → Diff=0x7F, Borrow=0, Ovf=1. Then 0x3C − 0x3C → Diff=0x00, Borrow=0, Ovf=0.
- Pulse Start again during SHIFT → ignored: one Done only, and L pulses exactly once.
- Drop RSTn low at SHIFT cycle 4 → all outputs 0 immediately. After release with Start, 0x10 − 0x01 → Diff=0x0F.
- Hold Start high continuously → back-to-back operations with Done every WIDTH+3 cycles, and Diff stable between Done pulses.
